multicycle_cu: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives per-state datapath strobes.
- Handshakes with variable-latency instruction and data memory via mem_req/mem_ready, with a parametrised timeout.
- Sits between the instruction register (opcode/funct) and the shared ALU/RF/memory datapath.

---
 rtl/multicycle_cu.sv | 265 ++++++++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout.
// Define MULTICYCLE_CU_PERF_EN to add the instret/stall_cnt performance counters.
`timescale 1ns/1ps
module multicycle_cu #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  to_reg,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        ext_sign,
    output logic [3:0]  alu_op,
    output logic [1:0]  mem_byte,
    output logic        mem_sign,
`ifdef MULTICYCLE_CU_PERF_EN
    output logic [31:0] instret,
    output logic [31:0] stall_cnt,
`endif
    output logic [2:0]  state,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    logic       dec_legal, dec_src_a, dec_src_b, dec_ext, dec_msign;
    logic [3:0] dec_alu_op;
    logic [1:0] dec_dst, dec_to_reg, dec_mbyte;
    logic       is_load, is_store, is_beq, is_bne, is_jump, is_jreg, is_link;
    logic       timeout, sel_en;

    always_comb begin : decode
        dec_legal  = 1'b1;
        dec_src_a  = 1'b0;
        dec_src_b  = 1'b0;
        dec_ext    = 1'b0;
        dec_msign  = 1'b0;
        dec_alu_op = 4'b0000;
        dec_dst    = 2'd0;
        dec_to_reg = 2'd0;
        dec_mbyte  = 2'b00;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_jump    = 1'b0;
        is_jreg    = 1'b0;
        is_link    = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00: begin dec_alu_op = 4'b1010; dec_src_a = 1'b1; end
                    6'h02: begin dec_alu_op = 4'b1100; dec_src_a = 1'b1; end
                    6'h03: begin dec_alu_op = 4'b1101; dec_src_a = 1'b1; end
                    6'h08: is_jreg = 1'b1;
                    6'h09: begin is_jreg = 1'b1; is_link = 1'b1; end
                    6'h20: dec_alu_op = 4'b0000;
                    6'h21: dec_alu_op = 4'b1000;
                    6'h22: dec_alu_op = 4'b0001;
                    6'h23: dec_alu_op = 4'b1001;
                    6'h24: dec_alu_op = 4'b0010;
                    6'h25: dec_alu_op = 4'b0011;
                    6'h26: dec_alu_op = 4'b0100;
                    6'h27: dec_alu_op = 4'b0101;
                    6'h2A: dec_alu_op = 4'b0110;
                    6'h2B: dec_alu_op = 4'b0111;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h02: is_jump = 1'b1;
            6'h03: begin is_jump = 1'b1; is_link = 1'b1; end
            6'h04: begin is_beq = 1'b1; dec_alu_op = 4'b0001; end
            6'h05: begin is_bne = 1'b1; dec_alu_op = 4'b0001; end
            6'h08: begin dec_alu_op = 4'b0000; dec_src_b = 1'b1; dec_ext = 1'b1; end
            6'h09: begin dec_alu_op = 4'b1000; dec_src_b = 1'b1; dec_ext = 1'b1; end
            6'h0A: begin dec_alu_op = 4'b0110; dec_src_b = 1'b1; dec_ext = 1'b1; end
            6'h0B: begin dec_alu_op = 4'b0111; dec_src_b = 1'b1; dec_ext = 1'b1; end
            6'h0C: begin dec_alu_op = 4'b0010; dec_src_b = 1'b1; end
            6'h0D: begin dec_alu_op = 4'b0011; dec_src_b = 1'b1; end
            6'h0E: begin dec_alu_op = 4'b0100; dec_src_b = 1'b1; end
            6'h0F: begin dec_alu_op = 4'b1011; dec_src_b = 1'b1; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load = 1'b1;
            6'h28, 6'h29, 6'h2B: is_store = 1'b1;
            default: dec_legal = 1'b0;
        endcase
        // Access size comes from opcode[1:0]: 00 byte, 01 half, 11 word.
        if (is_load || is_store) begin
            dec_src_b = 1'b1;
            dec_ext   = 1'b1;
            case (opcode[1:0])
                2'b00:   dec_mbyte = 2'b11;
                2'b01:   dec_mbyte = 2'b10;
                default: dec_mbyte = 2'b00;
            endcase
        end
        dec_msign = is_load & ~opcode[2];
        if (is_load) dec_to_reg = 2'd1;
        if (is_link) begin
            dec_dst    = 2'd2;
            dec_to_reg = 2'd2;
        end else if (dec_legal && opcode != 6'h00) begin
            dec_dst = 2'd1;
        end
    end

    assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign sel_en  = (state_q != S_IDLE) && (state_q != S_FAULT);

    // mem_req stays high in FETCH/MEM until the cycle mem_ready is seen; that cycle completes the access.
    always_comb begin : fsm_next
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = 2'd0;
        reg_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d = S_FAULT;
                end else if (is_jump || is_jreg) begin
                    pc_we   = 1'b1;
                    pc_src  = is_jump ? 2'd2 : 2'd3;
                    reg_we  = is_link;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq || is_bne) begin
                    pc_we   = (is_beq & zero) | (is_bne & ~zero);
                    pc_src  = 2'd1;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = is_load ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
        if (state_d == S_FAULT) fault_d = 1'b1;
    end

    always_comb begin : selects
        alu_op    = 4'b0000;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sign  = 1'b0;
        reg_dst   = 2'd0;
        to_reg    = 2'd0;
        mem_byte  = 2'b00;
        mem_sign  = 1'b0;
        if (sel_en) begin
            alu_op    = dec_alu_op;
            alu_src_a = dec_src_a;
            alu_src_b = dec_src_b;
            ext_sign  = dec_ext;
            reg_dst   = dec_dst;
            to_reg    = dec_to_reg;
            mem_byte  = dec_mbyte;
            mem_sign  = dec_msign;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign state = state_q;
    assign fault = fault_q;

`ifdef MULTICYCLE_CU_PERF_EN
    logic [31:0] instret_q, stall_q;
    logic        retire, stall;

    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});
    assign stall  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire) instret_q <= instret_q + 32'd1;
            if (stall)  stall_q   <= stall_q + 32'd1;
        end
    end

    assign instret   = instret_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: table-driven instruction model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_multicycle_cu;

    localparam int W   = 25;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;
    logic        mem_req, mem_we, ir_we, pc_we, reg_we;
    logic [1:0]  pc_src, reg_dst, to_reg, mem_byte;
    logic        alu_src_a, alu_src_b, ext_sign, mem_sign;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic        fault;
`ifdef MULTICYCLE_CU_PERF_EN
    logic [31:0] instret, stall_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_cu #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
        .to_reg(to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_sign(ext_sign), .alu_op(alu_op), .mem_byte(mem_byte), .mem_sign(mem_sign),
`ifdef MULTICYCLE_CU_PERF_EN
        .instret(instret), .stall_cnt(stall_cnt),
`endif
        .state(state), .fault(fault)
    );

    typedef enum int {C_R, C_SH, C_IS, C_IZ, C_LD, C_ST, C_BEQ, C_BNE,
                      C_J, C_JAL, C_JR, C_JALR, C_ILL} cls_t;
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        cls_t       cls;
        logic [3:0] alu;
        logic [1:0] mb;
        logic       ms;
    } instr_t;

    localparam int I_ADD = 0, I_JR = 13, I_JALR = 14, I_BEQ = 23, I_JAL = 26;
    localparam int I_LW = 29, I_SB = 32, I_SW = 34, I_ILL_OP = 35, I_ILL_FN = 36;
    localparam int N_LEGAL = 35;

    instr_t      tbl[$];
    logic [W-1:0] exp_q[$];
    string       side_name[$];
    logic [31:0] side_got[$];
    logic [31:0] side_exp[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_ret = 0;
    int          exp_stall = 0;
    logic [W-1:0] mon_exp, mon_got;

    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input cls_t c,
                             input logic [3:0] alu, input logic [1:0] mb, input logic ms);
        instr_t t;
        t.op = op; t.fn = fn; t.cls = c; t.alu = alu; t.mb = mb; t.ms = ms;
        tbl.push_back(t);
    endtask

    task automatic build_table();
        add_instr(6'h00, 6'h20, C_R, 4'b0000, 2'b00, 1'b0);
        add_instr(6'h00, 6'h21, C_R, 4'b1000, 2'b00, 1'b0);
        add_instr(6'h00, 6'h22, C_R, 4'b0001, 2'b00, 1'b0);
        add_instr(6'h00, 6'h23, C_R, 4'b1001, 2'b00, 1'b0);
        add_instr(6'h00, 6'h24, C_R, 4'b0010, 2'b00, 1'b0);
        add_instr(6'h00, 6'h25, C_R, 4'b0011, 2'b00, 1'b0);
        add_instr(6'h00, 6'h26, C_R, 4'b0100, 2'b00, 1'b0);
        add_instr(6'h00, 6'h27, C_R, 4'b0101, 2'b00, 1'b0);
        add_instr(6'h00, 6'h2A, C_R, 4'b0110, 2'b00, 1'b0);
        add_instr(6'h00, 6'h2B, C_R, 4'b0111, 2'b00, 1'b0);
        add_instr(6'h00, 6'h00, C_SH, 4'b1010, 2'b00, 1'b0);
        add_instr(6'h00, 6'h02, C_SH, 4'b1100, 2'b00, 1'b0);
        add_instr(6'h00, 6'h03, C_SH, 4'b1101, 2'b00, 1'b0);
        add_instr(6'h00, 6'h08, C_JR, 4'b0000, 2'b00, 1'b0);
        add_instr(6'h00, 6'h09, C_JALR, 4'b0000, 2'b00, 1'b0);
        add_instr(6'h08, 6'h00, C_IS, 4'b0000, 2'b00, 1'b0);
        add_instr(6'h09, 6'h00, C_IS, 4'b1000, 2'b00, 1'b0);
        add_instr(6'h0A, 6'h00, C_IS, 4'b0110, 2'b00, 1'b0);
        add_instr(6'h0B, 6'h00, C_IS, 4'b0111, 2'b00, 1'b0);
        add_instr(6'h0C, 6'h00, C_IZ, 4'b0010, 2'b00, 1'b0);
        add_instr(6'h0D, 6'h00, C_IZ, 4'b0011, 2'b00, 1'b0);
        add_instr(6'h0E, 6'h00, C_IZ, 4'b0100, 2'b00, 1'b0);
        add_instr(6'h0F, 6'h00, C_IZ, 4'b1011, 2'b00, 1'b0);
        add_instr(6'h04, 6'h00, C_BEQ, 4'b0001, 2'b00, 1'b0);
        add_instr(6'h05, 6'h00, C_BNE, 4'b0001, 2'b00, 1'b0);
        add_instr(6'h02, 6'h00, C_J, 4'b0000, 2'b00, 1'b0);
        add_instr(6'h03, 6'h00, C_JAL, 4'b0000, 2'b00, 1'b0);
        add_instr(6'h20, 6'h00, C_LD, 4'b0000, 2'b11, 1'b1);
        add_instr(6'h21, 6'h00, C_LD, 4'b0000, 2'b10, 1'b1);
        add_instr(6'h23, 6'h00, C_LD, 4'b0000, 2'b00, 1'b1);
        add_instr(6'h24, 6'h00, C_LD, 4'b0000, 2'b11, 1'b0);
        add_instr(6'h25, 6'h00, C_LD, 4'b0000, 2'b10, 1'b0);
        add_instr(6'h28, 6'h00, C_ST, 4'b0000, 2'b11, 1'b0);
        add_instr(6'h29, 6'h00, C_ST, 4'b0000, 2'b10, 1'b0);
        add_instr(6'h2B, 6'h00, C_ST, 4'b0000, 2'b00, 1'b0);
        add_instr(6'h3F, 6'h00, C_ILL, 4'b0000, 2'b00, 1'b0);
        add_instr(6'h00, 6'h01, C_ILL, 4'b0000, 2'b00, 1'b0);
    endtask

    // {reg_dst, to_reg, alu_src_a, alu_src_b, ext_sign, alu_op, mem_byte, mem_sign}
    function automatic logic [13:0] sel_of(input instr_t t);
        logic [1:0] dst, tr;
        logic a, b, e;
        if (t.cls inside {C_JAL, C_JALR})                dst = 2'd2;
        else if (t.cls inside {C_R, C_SH, C_JR, C_ILL})  dst = 2'd0;
        else                                             dst = 2'd1;
        if (t.cls inside {C_JAL, C_JALR}) tr = 2'd2;
        else if (t.cls == C_LD)           tr = 2'd1;
        else                              tr = 2'd0;
        a = (t.cls == C_SH);
        b = (t.cls inside {C_IS, C_IZ, C_LD, C_ST});
        e = (t.cls inside {C_IS, C_LD, C_ST});
        return {dst, tr, a, b, e, t.alu, t.mb, t.ms};
    endfunction

    function automatic logic [W-1:0] mk(input logic [2:0] st, input logic req, input logic we,
                                        input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                        input logic rwe, input logic [13:0] s, input logic flt);
        return {st, req, we, irwe, pcwe, pcs, rwe, s, flt};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic mr, input logic [W-1:0] e);
        mem_ready = mr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic side_check(input string name, input logic [31:0] got, input logic [31:0] exp);
        side_name.push_back(name);
        side_got.push_back(got);
        side_exp.push_back(exp);
    endtask

    task automatic fault_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            opcode = 6'($urandom_range(0, 63));
            step(rbit(), mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 14'd0, 1'b1));
        end
    endtask

    task automatic do_reset();
        logic [W-1:0] idle;
        idle = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 14'd0, 1'b0);
        opcode = tbl[$urandom_range(0, N_LEGAL - 1)].op;
        rst_n = 1'b0;
        exp_ret = 0;
        exp_stall = 0;
        step(rbit(), idle);
        step(rbit(), idle);
        rst_n = 1'b1;
        step(rbit(), idle);
    endtask

    task automatic check_perf();
`ifdef MULTICYCLE_CU_PERF_EN
        side_check("instret", instret, 32'(exp_ret));
        side_check("stall_cnt", stall_cnt, 32'(exp_stall));
`endif
    endtask

    task automatic async_abort();
        mem_ready = 1'b0;
        #1;
        side_check("mem_req_before_reset", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        side_check("mem_req_async_drop", {31'd0, mem_req}, 32'd0);
        side_check("state_async_idle", {29'd0, state}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction; flat/mlat are wait cycles before mem_ready in FETCH/MEM.
    task automatic issue(input int idx, input int flat, input int mlat, input logic z,
                         input int abort_at);
        instr_t t;
        logic [13:0] s;
        logic r, tk;
        t = tbl[idx];
        s = sel_of(t);
        opcode = t.op;
        funct  = (t.op == 6'h00) ? t.fn : 6'($urandom_range(0, 63));
        zero   = z;
        for (int k = 0; k <= flat; k++) begin
            r = (k == flat);
            if (!r) exp_stall++;
            step(r, mk(3'd1, 1'b1, 1'b0, r, r, 2'd0, 1'b0, s, 1'b0));
            if (!r && k == TMO) begin
                fault_cycles(4);
                return;
            end
        end
        case (t.cls)
            C_ILL: begin
                step(rbit(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, s, 1'b0));
                fault_cycles(4);
                return;
            end
            C_J, C_JAL: begin
                step(rbit(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, t.cls == C_JAL, s, 1'b0));
                exp_ret++;
                return;
            end
            C_JR, C_JALR: begin
                step(rbit(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, t.cls == C_JALR, s, 1'b0));
                exp_ret++;
                return;
            end
            default: step(rbit(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, s, 1'b0));
        endcase
        if (t.cls inside {C_BEQ, C_BNE}) begin
            tk = (t.cls == C_BEQ) ? z : !z;
            step(rbit(), mk(3'd3, 1'b0, 1'b0, 1'b0, tk, 2'd1, 1'b0, s, 1'b0));
            exp_ret++;
            return;
        end
        step(rbit(), mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, s, 1'b0));
        if (t.cls inside {C_LD, C_ST}) begin
            for (int k = 0; k <= mlat; k++) begin
                if (k == abort_at) begin
                    async_abort();
                    return;
                end
                r = (k == mlat);
                if (!r) exp_stall++;
                step(r, mk(3'd4, 1'b1, t.cls == C_ST, 1'b0, 1'b0, 2'd0, 1'b0, s, 1'b0));
                if (!r && k == TMO) begin
                    fault_cycles(4);
                    return;
                end
            end
            if (t.cls == C_ST) begin
                exp_ret++;
                return;
            end
        end
        step(rbit(), mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, s, 1'b0));
        exp_ret++;
    endtask

    always @(negedge clk) begin : monitor
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {state, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, to_reg,
                       alu_src_a, alu_src_b, ext_sign, alu_op, mem_byte, mem_sign, fault};
            n_cmp++;
            if (mon_got !== mon_exp) begin
                n_err++;
                $display("FAIL cycle_outputs t=%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
                         $time, mon_got[24:22], mon_got, mon_exp[24:22], mon_exp);
            end
        end
        while (side_got.size() > 0) begin
            string nm;
            logic [31:0] g, e;
            nm = side_name.pop_front();
            g  = side_got.pop_front();
            e  = side_exp.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s t=%0t: got %0d, expected %0d", nm, $time, g, e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int flat, mlat;
        build_table();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        opcode = 6'h00;
        funct = 6'h20;
        @(posedge clk);
        #1;
        do_reset();

        issue(I_ADD, 0, 0, 1'b0, -1);
        check_perf();
        issue(I_LW, 0, 3, 1'b0, -1);
        issue(I_BEQ, 0, 0, 1'b1, -1);
        issue(I_BEQ, 0, 0, 1'b0, -1);
        issue(I_JAL, 0, 0, 1'b0, -1);
        issue(I_JR, 1, 0, 1'b0, -1);
        issue(I_JALR, 0, 0, 1'b0, -1);
        issue(I_SW, 2, 1, 1'b0, -1);
        issue(I_LW, TMO, TMO, 1'b0, -1);
        check_perf();

        for (int i = 0; i < 80; i++) begin
            flat = ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, 3));
            mlat = ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, 3));
            issue(int'($urandom_range(0, N_LEGAL - 1)), flat, mlat, rbit(), -1);
        end
        check_perf();

        issue(I_ADD, TMO + 1, 0, 1'b0, -1);
        check_perf();
        do_reset();
        issue(I_ILL_OP, 0, 0, 1'b0, -1);
        do_reset();
        issue(I_ILL_FN, 1, 0, 1'b0, -1);
        do_reset();
        issue(I_LW, 0, TMO + 1, 1'b0, -1);
        check_perf();
        do_reset();
        issue(I_SB, 0, 5, 1'b0, 2);
        do_reset();
        issue(I_ADD, 0, 0, 1'b0, -1);
        check_perf();

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
